mem_port_arbiter: RTL and testbench

//  Shares the single RAM port between core instruction fetch (m0) and data (m1) masters.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one RAM port between instruction fetch (m0) and data (m1) masters.
// An in-order owner FIFO routes responses back to the issuer. Define ARB_FINISH_DETECT_EN to enable done_o.
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       MAX_OUTST   = 2,
    parameter logic [ADDR_W-1:0] FINISH_ADDR = 32'h003FFFFC
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o,
    output logic                done_o
);

    localparam int unsigned      CNT_W    = $clog2(MAX_OUTST + 1);
    localparam int unsigned      PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned      BE_W     = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Master ids: 1'b0 = m0 (fetch), 1'b1 = m1 (data).
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic any_req_s;
    logic full_s;
    logic sel_s;
    logic push_s;
    logic pop_s;
    logic stray_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return ptr + PTR_ONE;
        end
    endfunction

    // Arbitration, request forwarding and grant generation.
    always_comb begin
        any_req_s = m0_req_i | m1_req_i;
        full_s    = (count_q == CNT_FULL);
        if (m0_req_i && m1_req_i) begin
            sel_s = ~last_q;
        end else if (m1_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        s_req_o  = any_req_s & ~full_s;
        push_s   = s_req_o & s_gnt_i;
        m0_gnt_o = push_s & ~sel_s;
        m1_gnt_o = push_s & sel_s;
        // Request fields stay zero while idle so the RAM side sees a quiet bus.
        if (!any_req_s) begin
            s_addr_o  = {ADDR_W{1'b0}};
            s_we_o    = 1'b0;
            s_be_o    = {BE_W{1'b0}};
            s_wdata_o = {DATA_W{1'b0}};
        end else if (sel_s) begin
            s_addr_o  = m1_addr_i;
            s_we_o    = m1_we_i;
            s_be_o    = m1_be_i;
            s_wdata_o = m1_wdata_i;
        end else begin
            s_addr_o  = m0_addr_i;
            s_we_o    = 1'b0;
            s_be_o    = {BE_W{1'b1}};
            s_wdata_o = {DATA_W{1'b0}};
        end
    end

    // Response routing from the head of the owner FIFO.
    always_comb begin
        head_s      = owner_q[rd_ptr_q];
        pop_s       = s_rvalid_i & (count_q != CNT_ZERO);
        stray_s     = s_rvalid_i & (count_q == CNT_ZERO);
        m0_rvalid_o = pop_s & ~head_s;
        m1_rvalid_o = pop_s & head_s;
        m0_rdata_o  = s_rdata_i;
        m1_rdata_o  = s_rdata_i;
        err_o       = err_q;
    end

    // Owner FIFO, round-robin history and error flag next state.
    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        err_d    = err_q | stray_s;
        if (push_s) begin
            owner_d[wr_ptr_q] = sel_s;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
            last_d            = sel_s;
        end else begin
            wr_ptr_d = wr_ptr_q;
            last_d   = last_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers; last_q resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q  <= {MAX_OUTST{1'b0}};
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

`ifdef ARB_FINISH_DETECT_EN
    logic done_q, done_d;

    // Finish flag: sticky once a data-side write to FINISH_ADDR is granted.
    always_comb begin
        done_d = done_q | (m1_gnt_o & m1_we_i & (m1_addr_i == FINISH_ADDR));
        done_o = done_q;
    end

    // Finish flag register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
`else
    logic unused_finish_s;
    assign unused_finish_s = ^FINISH_ADDR;
    assign done_o          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences and a
// randomized phase checked against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          MO  = 2;
    localparam logic [31:0] FIN = 32'h003FFFFC;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          m0_req_i, m1_req_i, m1_we_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [3:0]    m1_be_i;
    logic [DW-1:0] m1_wdata_i;
    logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          s_req_o, s_we_o;
    logic [AW-1:0] s_addr_o;
    logic [3:0]    s_be_o;
    logic [DW-1:0] s_wdata_o;
    logic          s_gnt_i, s_rvalid_i;
    logic [DW-1:0] s_rdata_i;
    logic          err_o, done_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .FINISH_ADDR(FIN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .err_o(err_o), .done_o(done_o)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model: owners of outstanding transactions, last winner, sticky flags.
    int q[$];
    int last_win = 1;
    bit err_m    = 1'b0;
    bit done_m   = 1'b0;

    typedef struct {
        bit         r0;
        bit         r1;
        bit         we;
        bit         g;
        bit         rv;
        logic [4:0] e;   // {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit r0, input bit r1, input bit we, input bit g, input bit rv);
        m0_req_i   = r0;
        m1_req_i   = r1;
        m1_we_i    = we;
        s_gnt_i    = g;
        s_rvalid_i = rv;
    endtask

    task automatic model_eval(output logic [4:0] e, output bit win);
        bit any, full, g, r0, r1;
        any  = m0_req_i | m1_req_i;
        full = (q.size() >= MO);
        if (m0_req_i && m1_req_i) win = (last_win == 0);
        else                      win = m1_req_i;
        g  = s_gnt_i & any & !full;
        r0 = 1'b0;
        r1 = 1'b0;
        if (s_rvalid_i && q.size() > 0) begin
            r0 = (q[0] == 0);
            r1 = (q[0] == 1);
            void'(q.pop_front());
        end else if (s_rvalid_i) begin
            err_m = 1'b1;
        end
        if (g) begin
            q.push_back(int'(win));
            last_win = int'(win);
`ifdef ARB_FINISH_DETECT_EN
            if (win && m1_we_i && m1_addr_i == FIN) done_m = 1'b1;
`endif
        end
        e = {any & !full, g & !win, g & win, r0, r1};
    endtask

    task automatic cycle(input string tag, input bit use_tbl, input logic [4:0] tbl_e);
        logic [4:0] e;
        bit         win;
        @(negedge clk);
        chk({tag, " err"}, err_o, err_m);
        chk({tag, " done"}, done_o, done_m);
        model_eval(e, win);
        chk({tag, " handshake"}, {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o},
            use_tbl ? tbl_e : e);
        if (e[4]) begin
            chk({tag, " s_addr"}, s_addr_o, win ? m1_addr_i : m0_addr_i);
            chk({tag, " s_fields"}, {s_we_o, s_be_o, s_wdata_o},
                win ? {m1_we_i, m1_be_i, m1_wdata_i} : {1'b0, 4'hF, 32'h0});
        end
        if (e[1]) chk({tag, " m0_rdata"}, m0_rdata_o, s_rdata_i);
        if (e[0]) chk({tag, " m1_rdata"}, m1_rdata_o, s_rdata_i);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        q.delete();
        last_win = 1;
        err_m    = 1'b0;
        done_m   = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10100};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11001};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b10110};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b11000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00001};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00010};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10000};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10100};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10100};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b00000};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b00001};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10100};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00001};

        m0_addr_i  = 32'h0;
        m1_addr_i  = 32'h0;
        m1_be_i    = 4'h0;
        m1_wdata_i = 32'h0;
        s_rdata_i  = 32'h0;
        do_reset();

        // Reset state: idle bus, no flags.
        @(negedge clk);
        chk("reset bus", {s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o}, 64'h0);
        chk("reset flags", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o, done_o}, 64'h0);
        @(posedge clk);
        #1;

        // Single fetch: same-cycle grant, response one cycle later.
        m0_addr_i = 32'h0000_0100;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("t1_req", 1'b1, 5'b11000);
        s_rdata_i = 32'hA5A5_A5A5;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("t1_rsp", 1'b1, 5'b00010);
        chk("t1 rdata", m0_rdata_o, 32'hA5A5_A5A5);

        // Vector table: alternation, full FIFO, stalled RAM grant.
        for (int i = 0; i < 22; i++) begin
            m0_addr_i  = 32'h1000 + 32'(i * 4);
            m1_addr_i  = 32'h2000 + 32'(i * 4);
            m1_be_i    = 4'(i);
            m1_wdata_i = $urandom;
            s_rdata_i  = $urandom;
            set_in(tbl[i].r0, tbl[i].r1, tbl[i].we, tbl[i].g, tbl[i].rv);
            cycle($sformatf("tbl%0d", i), 1'b1, tbl[i].e);
        end

        // Stray response with empty FIFO: dropped, sticky error until reset.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("t5_stray", 1'b1, 5'b00000);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("t5_hold", 1'b0, 5'b00000);
        chk("t5 err sticky", err_o, 1'b1);
        do_reset();
        cycle("t5_cleared", 1'b0, 5'b00000);

        // Finish write (and a read of the same address afterwards).
        m1_addr_i  = FIN;
        m1_be_i    = 4'hF;
        m1_wdata_i = 32'h1;
        set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("t6_wr", 1'b1, 5'b10100);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("t6_ack", 1'b1, 5'b00001);
`ifdef ARB_FINISH_DETECT_EN
        chk("t6 done set", done_o, 1'b1);
`else
        chk("t6 done tied", done_o, 1'b0);
`endif
        do_reset();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle("t6_rd", 1'b1, 5'b10100);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("t6_rd_ack", 1'b1, 5'b00001);
        chk("t6 read no done", done_o, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m0_addr_i  = $urandom & 32'h000F_FFFC;
            m1_addr_i  = $urandom & 32'h000F_FFFC;
            m1_be_i    = 4'($urandom);
            m1_wdata_i = $urandom;
            s_rdata_i  = $urandom;
            set_in(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                   (q.size() > 0) && 1'($urandom));
            cycle("rand", 1'b0, 5'b00000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
